nn_layer_seq: RTL and testbench

//  Parametrised, time-multiplexed perceptron layer: NUM_NEURON step-activation neurons over a
//  NUM_IN-bit binary input vector, sharing one signed MAC datapath.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/nn_mac_acc.sv | 41 ++++
 rtl/nn_layer_seq.sv | 182 ++++++++++++++++++
 tb/tb_nn_layer_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the time-multiplexed perceptron layer.
//   state_e : layer sequencer states
//   clog2   : ceiling log2 with a minimum of one bit, for counter/index widths
//   sext    : sign-extends the low w bits of a value to 64 bits
package nn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/nn_mac_acc.sv
// Signed accumulator for the shared MAC datapath.
//   clk, rst_n : clock, asynchronous active-low reset (acc clears to 0)
//   load       : replace acc with load_val (bias of the next neuron)
//   load_val   : sign-extended bias
//   add_en     : add add_val this cycle (input bit set)
//   add_val    : sign-extended weight
//   sum_pos    : (acc + addend) > 0, signed strict; the sum includes the
//                addend of the current cycle so the last step of a neuron
//                can be judged in the same cycle it is accumulated
module nn_mac_acc #(
    parameter int unsigned ACC_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_val,
    input  logic             add_en,
    input  logic [ACC_W-1:0] add_val,
    output logic             sum_pos
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum   = acc_q + (add_en ? add_val : '0);
        acc_d = load ? load_val : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_pos = ~sum[ACC_W-1] & (sum != '0);

endmodule

// File: rtl/nn_layer_seq.sv
// Time-multiplexed perceptron layer: NUM_NEURON step-activation neurons over
// a NUM_IN-bit binary input vector, one shared signed MAC.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/wr_neuron/
//   wr_idx/wr_data      : weight (idx < NUM_IN) or bias (idx == NUM_IN) write
//   wr_err              : one-cycle pulse when a write is rejected
//   in_valid/in_ready/
//   in_vec              : input vector handshake
//   out_valid/out_ready/
//   out_vec             : result handshake, bit n = activation of neuron n
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int unsigned NUM_IN     = 5,
    parameter int unsigned NUM_NEURON = 4,
    parameter int unsigned W          = 8,
    parameter int unsigned ACC_W      = W + $clog2(NUM_IN + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [clog2(NUM_NEURON)-1:0]  wr_neuron,
    input  logic [clog2(NUM_IN + 1)-1:0]  wr_idx,
    input  logic [W-1:0]                  wr_data,
    output logic                          wr_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_IN-1:0]             in_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_NEURON-1:0]         out_vec
);

    localparam int unsigned NW   = clog2(NUM_NEURON);
    localparam int unsigned KW   = clog2(NUM_IN + 1);
    localparam int unsigned BANK = NUM_NEURON * (NUM_IN + 1);
    localparam int unsigned BW   = clog2(BANK);
    localparam int unsigned NMW  = 1 << NW;
    localparam int unsigned KMW  = 1 << KW;

    // Address-validity lookup tables indexed directly by the write address
    localparam logic [NMW-1:0] NEURON_OK = NMW'((64'd1 << NUM_NEURON) - 64'd1);
    localparam logic [KMW-1:0] IDX_OK    = KMW'((64'd1 << (NUM_IN + 1)) - 64'd1);

    function automatic logic [BW-1:0] bank_addr(input logic [NW-1:0] n, input logic [KW-1:0] k);
        return BW'(n) * BW'(NUM_IN + 1) + BW'(k);
    endfunction

    state_e                state_q, state_d;
    logic [NW-1:0]         n_q, n_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NUM_IN-1:0]     vec_q, vec_d;
    logic [NUM_NEURON-1:0] out_vec_q, out_vec_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_err_q, wr_err_d;
    logic [W-1:0]          bank_q [BANK];
    logic [W-1:0]          bank_d [BANK];

    logic                  wr_ok;
    logic [NW-1:0]         nb_n;
    logic [W-1:0]          bias0;
    logic                  acc_load;
    logic [ACC_W-1:0]      acc_load_val;
    logic                  acc_add_en;
    logic [ACC_W-1:0]      acc_add_val;
    logic                  acc_sum_pos;

    nn_mac_acc #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc_load),
        .load_val (acc_load_val),
        .add_en   (acc_add_en),
        .add_val  (acc_add_val),
        .sum_pos  (acc_sum_pos)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        vec_d        = vec_q;
        out_vec_d    = out_vec_q;
        out_valid_d  = out_valid_q;
        in_ready_d   = in_ready_q;
        bank_d       = bank_q;
        acc_load     = 1'b0;
        acc_load_val = '0;
        acc_add_en   = 1'b0;
        acc_add_val  = ACC_W'(sext(64'(bank_q[bank_addr(n_q, k_q)]), W));

        wr_ok    = wr_en && (state_q == S_IDLE) && NEURON_OK[wr_neuron] && IDX_OK[wr_idx];
        wr_err_d = wr_en && !wr_ok;
        if (wr_ok) begin
            bank_d[bank_addr(wr_neuron, wr_idx)] = wr_data;
        end

        // A bias-0 write in the accepting cycle must reach the accumulator
        // load that happens on the same edge.
        if (wr_ok && (wr_neuron == '0) && (wr_idx == KW'(NUM_IN))) begin
            bias0 = wr_data;
        end else begin
            bias0 = bank_q[bank_addr('0, KW'(NUM_IN))];
        end

        nb_n = (n_q == NW'(NUM_NEURON - 1)) ? '0 : n_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d        = in_vec;
                    n_d          = '0;
                    k_d          = '0;
                    acc_load     = 1'b1;
                    acc_load_val = ACC_W'(sext(64'(bias0), W));
                    in_ready_d   = 1'b0;
                    state_d      = S_MAC;
                end
            end
            S_MAC: begin
                acc_add_en = vec_q[k_q];
                if (k_q == KW'(NUM_IN - 1)) begin
                    out_vec_d[n_q] = acc_sum_pos;
                    k_d            = '0;
                    if (n_q == NW'(NUM_NEURON - 1)) begin
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        n_d          = nb_n;
                        acc_load     = 1'b1;
                        acc_load_val = ACC_W'(sext(64'(bank_q[bank_addr(nb_n, KW'(NUM_IN))]), W));
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            vec_q       <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            wr_err_q    <= 1'b0;
            bank_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            vec_q       <= vec_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            wr_err_q    <= wr_err_d;
            bank_q      <= bank_d;
        end
    end

    assign wr_err    = wr_err_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
module tb_nn_layer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_neuron = '0;
    logic [2:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic       wr_err;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_vec = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_vec;

    int checks = 0;
    int errors = 0;
    int wm [4][6];
    logic [3:0] sb [$];

    nn_layer_seq #(
        .NUM_IN     (5),
        .NUM_NEURON (4),
        .W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_neuron (wr_neuron),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [4:0] v);
        logic [3:0] r;
        int acc;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            acc = wm[n][5];
            for (int k = 0; k < 5; k++) begin
                if (v[k]) acc += wm[n][k];
            end
            r[n] = (acc > 0);
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 6; i++)
                wm[n][i] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int n, input int idx, input int d, input bit exp_err);
        wr_en     = 1'b1;
        wr_neuron = 2'(n);
        wr_idx    = 3'(idx);
        wr_data   = 8'(d);
        step();
        wr_en = 1'b0;
        check("wr_err", wr_err, exp_err);
        if (!exp_err) wm[n][idx] = d;
    endtask

    task automatic wr_all(input int d);
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 6; i++)
                wr(n, i, d, 1'b0);
    endtask

    task automatic wait_out(input bit chk_lat);
        int lat;
        logic [3:0] exp;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("out_valid_seen", out_valid, 1);
        if (chk_lat) check("latency", lat, 20);
        exp = 'x;
        if (sb.size() > 0) exp = sb.pop_front();
        check("out_vec", out_vec, exp);
    endtask

    task automatic complete();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic run_vec(input logic [4:0] v, input bit chk_lat);
        check("in_ready_idle", in_ready, 1);
        in_vec   = v;
        in_valid = 1'b1;
        sb.push_back(model(v));
        step();
        in_valid = 1'b0;
        check("in_ready_mac", in_ready, 0);
        wait_out(chk_lat);
        complete();
    endtask

    initial begin
        logic [3:0] exp_a;
        logic [4:0] vb;
        clear_model();

        // 1: asynchronous reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_err", wr_err, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 2: neuron 0 weights 1..5, bias -7
        for (int k = 0; k < 5; k++) wr(0, k, k + 1, 1'b0);
        wr(0, 5, -7, 1'b0);
        run_vec(5'b00111, 1'b1);
        run_vec(5'b01111, 1'b1);

        // 3: extremes and the zero tie
        wr_all(-128);
        run_vec(5'b11111, 1'b1);
        wr_all(127);
        run_vec(5'b11111, 1'b1);
        wr_all(0);
        run_vec(5'b11111, 1'b1);
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 4; n++)
                for (int i = 0; i < 6; i++)
                    wr(n, i, int'($urandom_range(0, 255)) - 128, 1'b0);
            run_vec(5'($urandom_range(0, 31)), 1'b1);
        end

        // 4: backpressure, ignored second vector, write rejected in DONE
        wr_all(0);
        wr(1, 5, 1, 1'b0);
        wr(3, 2, 9, 1'b0);
        wr(3, 5, -5, 1'b0);
        exp_a = model(5'b00100);
        check("in_ready_idle", in_ready, 1);
        in_vec   = 5'b00100;
        in_valid = 1'b1;
        sb.push_back(exp_a);
        step();
        in_valid = 1'b0;
        wait_out(1'b1);
        vb       = 5'b00000;
        in_vec   = vb;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            wr_en     = (i == 10);
            wr_neuron = 2'd1;
            wr_idx    = 3'd5;
            wr_data   = 8'd100;
            step();
            check("stall_out_valid", out_valid, 1);
            check("stall_out_vec", out_vec, exp_a);
            check("stall_in_ready", in_ready, 0);
            check("stall_wr_err", wr_err, (i == 10));
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready", in_ready, 1);
        sb.push_back(model(vb));
        step();
        in_valid = 1'b0;
        check("bp_second_accepted", in_ready, 0);
        wait_out(1'b1);
        complete();

        // 5: rejected writes and same-cycle write + input
        wr_all(0);
        wr(0, 5, -1, 1'b0);
        in_vec   = 5'b00001;
        in_valid = 1'b1;
        sb.push_back(model(5'b00001));
        step();
        in_valid = 1'b0;
        step();
        step();
        wr_en     = 1'b1;
        wr_neuron = 2'd0;
        wr_idx    = 3'd0;
        wr_data   = 8'd99;
        step();
        wr_en = 1'b0;
        check("mac_wr_err", wr_err, 1);
        step();
        check("mac_wr_err_pulse", wr_err, 0);
        wait_out(1'b0);
        complete();
        run_vec(5'b00001, 1'b1);
        wr(0, 6, 50, 1'b1);
        step();
        check("bad_idx_pulse", wr_err, 0);
        wr(2, 7, 50, 1'b1);
        run_vec(5'b00001, 1'b1);
        wr_en     = 1'b1;
        wr_neuron = 2'd0;
        wr_idx    = 3'd5;
        wr_data   = 8'd5;
        in_vec    = 5'b00000;
        in_valid  = 1'b1;
        wm[0][5]  = 5;
        sb.push_back(model(5'b00000));
        step();
        wr_en    = 1'b0;
        in_valid = 1'b0;
        check("same_cycle_wr_err", wr_err, 0);
        wait_out(1'b1);
        complete();
        wr_en     = 1'b1;
        wr_neuron = 2'd2;
        wr_idx    = 3'd4;
        wr_data   = 8'd3;
        in_vec    = 5'b10000;
        in_valid  = 1'b1;
        wm[2][4]  = 3;
        sb.push_back(model(5'b10000));
        step();
        wr_en    = 1'b0;
        in_valid = 1'b0;
        wait_out(1'b1);
        complete();

        // 6: reset in the middle of a computation
        wr_all(10);
        run_vec(5'b11111, 1'b1);
        in_vec   = 5'b11111;
        in_valid = 1'b1;
        sb.push_back(model(5'b11111));
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_vec", out_vec, 0);
        step();
        rst_n = 1'b1;
        sb.delete();
        clear_model();
        step();
        run_vec(5'b11111, 1'b1);
        run_vec(5'b10101, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
